load_extend_controller: RTL

- Multi-cycle load sequencer between the execute stage and the data memory port.
- Accepts one load request at a time, issues a word-aligned memory read and waits for acknowledge.
- Selects the addressed byte, halfword or word lane, then sign- or zero-extends it to XLEN and presents it for writeback.
- Detects misaligned addresses, illegal load funct3 values and memory timeouts, and reports each as a fault instead of writing back.

---
 rtl/load_extend_controller.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_extend_controller.sv
// -----------------------------------------------------------------------------
// load_extend_controller
//
// Multi-cycle load sequencer sitting between the execute stage and the data
// memory port. It takes one load at a time, issues a word-aligned read, waits
// for the memory acknowledge, then picks out the addressed byte/halfword/word
// lane and sign- or zero-extends it for writeback. Misaligned addresses,
// illegal funct3 encodings and memory timeouts produce a one-cycle fault pulse
// instead of a writeback.
//
// Handshake: a request is taken on any rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so req_valid is
// ignored in every other state. The memory side is a request/acknowledge pair:
// mem_req and mem_addr are held stable from the first WAIT cycle until the
// cycle in which mem_ack is sampled high. mem_ack outside WAIT is ignored.
//
// Ports:
//   clk, reset   - single clock, synchronous active-high reset
//   req_valid    - load request valid
//   req_ready    - controller can accept a request (IDLE only)
//   req_funct3   - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   req_addr     - byte address
//   req_rd       - destination register
//   mem_req      - memory read request, held until mem_ack
//   mem_addr     - word-aligned read address
//   mem_ack      - read data valid this cycle
//   mem_rdata    - read word
//   wb_valid     - one-cycle pulse, wb_rd/wb_data valid
//   wb_rd        - destination register of the result
//   wb_data      - extended load result (holds between pulses)
//   fault        - one-cycle pulse, load aborted
//   fault_cause  - 01 misaligned, 10 timeout, 11 illegal funct3, 00 otherwise
//   fault_addr   - offending byte address, valid with fault
//   busy         - high in any state other than IDLE
// -----------------------------------------------------------------------------
module load_extend_controller #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_addr,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0]  CAUSE_ILLEGAL  = 2'b11;
  // The counter starts at 0 in the first WAIT cycle, so reaching this value
  // means TIMEOUT_CYCLES WAIT cycles have elapsed without an acknowledge.
  localparam logic [15:0] WAIT_LAST      = 16'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_next;

  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [4:0]        rd_q;
  logic [15:0]       wait_cnt;
  logic [XLEN-1:0]   mem_addr_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [1:0]        cause_q;
  logic [XLEN-1:0]   fault_addr_q;

  logic              illegal_f3;
  logic              misaligned;
  logic              timeout_hit;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [XLEN-1:0]   ext_data;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  // Illegal encodings are 011, 110 and 111; they win over misalignment.
  assign illegal_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // Lane select and extension, driven from the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
  end

  assign half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext_data = mem_rdata;
    case (funct3_q[1:0])
      // funct3[2] selects zero-extension (LBU/LHU)
      2'b00:   ext_data = {{(XLEN-8){byte_lane[7] & ~funct3_q[2]}}, byte_lane};
      2'b01:   ext_data = {{(XLEN-16){half_lane[15] & ~funct3_q[2]}}, half_lane};
      default: ext_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal_f3 || misaligned) begin
            state_next = S_FAULT;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An acknowledge in the last allowed cycle still completes the load.
        if (mem_ack) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_FAULT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      rd_q         <= 5'd0;
      wait_cnt     <= 16'd0;
      mem_addr_q   <= '0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= '0;
      cause_q      <= 2'b00;
      fault_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            rd_q     <= req_rd;
            wait_cnt <= 16'd0;
            if (illegal_f3) begin
              cause_q      <= CAUSE_ILLEGAL;
              fault_addr_q <= req_addr;
            end else if (misaligned) begin
              cause_q      <= CAUSE_MISALIGN;
              fault_addr_q <= req_addr;
            end else begin
              mem_addr_q <= {req_addr[XLEN-1:2], 2'b00};
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            wb_data_q <= ext_data;
            wb_rd_q   <= rd_q;
          end else if (timeout_hit) begin
            cause_q      <= CAUSE_TIMEOUT;
            fault_addr_q <= addr_q;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all are decoded from registered state, so none is combinational
  // from an input.
  // ---------------------------------------------------------------------------
  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign mem_req     = (state == S_WAIT);
  assign mem_addr    = mem_addr_q;
  assign wb_valid    = (state == S_DONE);
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign fault       = (state == S_FAULT);
  assign fault_cause = (state == S_FAULT) ? cause_q : 2'b00;
  assign fault_addr  = fault_addr_q;

endmodule
